// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch queue.
//  ifq_entry_t   : one queue entry, {pc, inst}
//  ifq_slot_pc() : PC of slot k of a fetch beat whose slot 0 is at base
package inst_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    // Instructions are 4 bytes, so slot k sits 4*k bytes after slot 0.
    function automatic logic [31:0] ifq_slot_pc(input logic [31:0] base, input int unsigned slot);
        return base + (32'(slot) << 2);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_chk.sv
// Simulation-only checker for the fetch queue consumer interface.
//  clk, resetn  : queue clock / reset
//  out_valid    : thermometer of presented entries
//  out_consume  : entries the consumer claims to take
module inst_fetch_queue_chk #(
    parameter int ISSUE_W = 2
) (
    input logic                            clk,
    input logic                            resetn,
    input logic [ISSUE_W-1:0]              out_valid,
    input logic [$clog2(ISSUE_W+1)-1:0]    out_consume
);

    localparam int CONS_W = $clog2(ISSUE_W + 1);

    logic [CONS_W-1:0] valid_cnt_s;

    // Number of entries currently presented to issue.
    always_comb begin
        valid_cnt_s = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            valid_cnt_s = valid_cnt_s + CONS_W'(out_valid[k]);
        end
    end

    // The queue clamps over-consume, but it always indicates a consumer bug.
    a_no_over_consume: assert property (@(posedge clk) disable iff (!resetn)
        out_consume <= valid_cnt_s)
        else $error("inst_fetch_queue: out_consume exceeds presented entries");

endmodule

// File: rtl/inst_fetch_queue_compactor.sv
// Combinational compactor: packs the valid slots of a fetch beat into the low
// output slots in ascending slot order, removing gaps, and counts them.
//  in_pc    : PC of slot 0
//  in_mask  : per-slot valid
//  in_data  : slot k at [32k+31:32k]
//  slot     : packed entries, slot 0 = lowest set mask bit
//  slot_cnt : popcount(in_mask)
module inst_fetch_queue_compactor
    import inst_fetch_queue_pkg::*;
#(
    parameter int FETCH_W = 2
) (
    input  logic [31:0]                      in_pc,
    input  logic [FETCH_W-1:0]               in_mask,
    input  logic [FETCH_W*32-1:0]            in_data,
    output ifq_entry_t [FETCH_W-1:0]         slot,
    output logic [$clog2(FETCH_W+1)-1:0]     slot_cnt
);

    localparam int FCNT_W = $clog2(FETCH_W + 1);

    logic [FCNT_W-1:0] pos_s;

    // Each set input slot lands at the output position equal to the number of
    // set slots below it.
    always_comb begin
        slot  = '0;
        pos_s = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            for (int j = 0; j < FETCH_W; j++) begin
                if (in_mask[k] && (pos_s == FCNT_W'(j))) begin
                    slot[j].pc   = ifq_slot_pc(in_pc, k);
                    slot[j].inst = in_data[32*k +: 32];
                end else begin
                    slot[j] = slot[j];
                end
            end
            pos_s = pos_s + FCNT_W'(in_mask[k]);
        end
        slot_cnt = pos_s;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and issue. Circular buffer of DEPTH
// {pc, inst} entries; compacts partially valid fetch beats, presents up to
// ISSUE_W head entries combinationally, and drops everything on flush.
//  clk, resetn  : clock, async active-low reset
//  flush        : drop all entries (priority over enqueue/dequeue)
//  in_valid/in_ready/in_pc/in_mask/in_data : fetch beat
//  out_valid/out_pc/out_inst : head entries, thermometer valid
//  out_consume  : number of head entries taken this cycle
//  count        : occupancy
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [31:0]                     in_pc,
    input  logic [FETCH_W-1:0]              in_mask,
    input  logic [FETCH_W*32-1:0]           in_data,
    output logic [ISSUE_W-1:0]              out_valid,
    output logic [ISSUE_W*32-1:0]           out_pc,
    output logic [ISSUE_W*32-1:0]           out_inst,
    input  logic [$clog2(ISSUE_W+1)-1:0]    out_consume,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FCNT_W = $clog2(FETCH_W + 1);

    ifq_entry_t               mem_q [DEPTH];
    ifq_entry_t               mem_d [DEPTH];
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    ifq_entry_t [FETCH_W-1:0] slot_s;
    logic [FCNT_W-1:0]        slot_cnt_s;
    logic                     enq_s;
    logic [CNT_W-1:0]         avail_s;
    logic [CNT_W-1:0]         eff_s;
    logic [CNT_W-1:0]         add_s;

    inst_fetch_queue_compactor #(
        .FETCH_W (FETCH_W)
    ) u_compactor (
        .in_pc    (in_pc),
        .in_mask  (in_mask),
        .in_data  (in_data),
        .slot     (slot_s),
        .slot_cnt (slot_cnt_s)
    );

    // Conservative: based on current occupancy only, so out_consume never
    // reaches in_ready combinationally.
    assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
    assign enq_s    = in_valid & in_ready & ~flush;
    assign count    = count_q;

    // Dequeue amount, clamped to the entries actually presented.
    always_comb begin
        if (count_q >= CNT_W'(ISSUE_W)) begin
            avail_s = CNT_W'(ISSUE_W);
        end else begin
            avail_s = count_q;
        end
        if (CNT_W'(out_consume) > avail_s) begin
            eff_s = avail_s;
        end else begin
            eff_s = CNT_W'(out_consume);
        end
    end

    // Pointer and occupancy next state; flush overrides enqueue and dequeue.
    always_comb begin
        if (enq_s) begin
            add_s = CNT_W'(slot_cnt_s);
        end else begin
            add_s = '0;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(eff_s);
            tail_d  = tail_q + PTR_W'(add_s);
            count_d = count_q + add_s - eff_s;
        end
    end

    // Write port: compacted slot j goes to tail+j when it carries an instruction.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < FETCH_W; j++) begin
            mem_d[tail_q + PTR_W'(j)] = (enq_s && (FCNT_W'(j) < slot_cnt_s))
                                        ? slot_s[j] : mem_d[tail_q + PTR_W'(j)];
        end
    end

    // Read muxes: entry head+k, no bypass from the write port.
    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_inst  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid[k]       = (count_q > CNT_W'(k));
            out_pc[32*k +: 32]   = mem_q[head_q + PTR_W'(k)].pc;
            out_inst[32*k +: 32] = mem_q[head_q + PTR_W'(k)].inst;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage; deliberately not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=8, FETCH_W=2, ISSUE_W=2).
// Stimulus pushes expected {pc, inst} per accepted instruction into a queue;
// a negedge monitor pops and compares every entry the consumer takes.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'd0;
    logic [1:0]  in_mask = 2'b00;
    logic [63:0] in_data = 64'd0;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_inst;
    logic [1:0]  out_consume = 2'd0;
    logic [3:0]  count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH   (8),
        .FETCH_W (2),
        .ISSUE_W (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_mask     (in_mask),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_consume (out_consume),
        .count       (count)
    );

    inst_fetch_queue_chk #(
        .ISSUE_W (2)
    ) u_chk (
        .clk         (clk),
        .resetn      (resetn),
        .out_valid   (out_valid),
        .out_consume (out_consume)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch beat held for one cycle; expected entries queued if it should be accepted.
    task automatic beat(input logic [31:0] pc, input logic [1:0] mask, input logic [31:0] d1,
                        input logic [31:0] d0, input logic [1:0] cons, input bit accept);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_mask     = mask;
        in_data     = {d1, d0};
        out_consume = cons;
        if (accept) begin
            if (mask[0]) exp_q.push_back({pc, d0});
            if (mask[1]) exp_q.push_back({pc + 32'd4, d1});
        end
        tick();
        in_valid    = 1'b0;
        in_mask     = 2'b00;
        out_consume = 2'd0;
    endtask

    task automatic consume(input logic [1:0] cons, input int cycles);
        out_consume = cons;
        repeat (cycles) tick();
        out_consume = 2'd0;
    endtask

    // Scoreboard monitor: every consumed head entry must match the next expected one.
    always @(negedge clk) begin
        if (resetn && !flush) begin
            for (int k = 0; k < 2; k++) begin
                if (k < int'(out_consume)) begin
                    if (!out_valid[k]) begin
                        chk("consume_valid", 64'(out_valid[k]), 64'd1);
                    end else if (exp_q.size() == 0) begin
                        chk("scoreboard_depth", 64'(exp_q.size()), 64'd1);
                    end else begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        chk("issue_pc", 64'(out_pc[32*k +: 32]), 64'(e[63:32]));
                        chk("issue_inst", 64'(out_inst[32*k +: 32]), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    initial begin
        // Reset state.
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // Full beat, 1-cycle latency.
        beat(32'hBFC0_0000, 2'b11, 32'h0000_000B, 32'h0000_000A, 2'd0, 1'b1);
        chk("full_count", 64'(count), 64'd2);
        chk("full_out_valid", 64'(out_valid), 64'd3);
        chk("full_out_pc", out_pc, 64'hBFC0_0004_BFC0_0000);
        chk("full_out_inst", out_inst, 64'h0000_000B_0000_000A);
        consume(2'd2, 1);
        chk("drain1_count", 64'(count), 64'd0);

        // Partial beat: only slot 1 valid, compacted to the head.
        beat(32'hBFC0_0008, 2'b10, 32'h0000_000D, 32'hDEAD_DEAD, 2'd0, 1'b1);
        chk("part_count", 64'(count), 64'd1);
        chk("part_out_valid", 64'(out_valid), 64'd1);
        chk("part_out_pc", 64'(out_pc[31:0]), 64'hBFC0_000C);
        chk("part_out_inst", 64'(out_inst[31:0]), 64'h0000_000D);
        consume(2'd1, 1);

        // Fill to DEPTH; the fifth beat must be ignored.
        for (int i = 0; i < 4; i++) begin
            beat(32'h0000_1000 + 32'(8*i), 2'b11, 32'h0000_0101 + 32'(2*i),
                 32'h0000_0100 + 32'(2*i), 2'd0, 1'b1);
        end
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        beat(32'h0000_2000, 2'b11, 32'h0000_0201, 32'h0000_0200, 2'd0, 1'b0);
        chk("over_count", 64'(count), 64'd8);
        chk("over_head_pc", out_pc, 64'h0000_1004_0000_1000);
        consume(2'd2, 4);
        chk("fill_drain_count", 64'(count), 64'd0);
        chk("fill_sb_empty", 64'(exp_q.size()), 64'd0);

        // Streaming with wrap: head and tail pass index 7.
        beat(32'h0000_3000, 2'b11, 32'h0000_0301, 32'h0000_0300, 2'd0, 1'b1);
        for (int i = 1; i < 6; i++) begin
            beat(32'h0000_3000 + 32'(8*i), 2'b11, 32'h0000_0301 + 32'(2*i),
                 32'h0000_0300 + 32'(2*i), 2'd2, 1'b1);
            chk("wrap_count", 64'(count), 64'd2);
        end
        consume(2'd2, 1);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with simultaneous enqueue and consume.
        beat(32'h0000_4000, 2'b11, 32'h0000_0401, 32'h0000_0400, 2'd0, 1'b1);
        beat(32'h0000_4008, 2'b11, 32'h0000_0403, 32'h0000_0402, 2'd0, 1'b1);
        chk("preflush_count", 64'(count), 64'd4);
        flush       = 1'b1;
        in_valid    = 1'b1;
        in_pc       = 32'h0000_5000;
        in_mask     = 2'b11;
        in_data     = {32'h0000_0501, 32'h0000_0500};
        out_consume = 2'd2;
        tick();
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_mask     = 2'b00;
        out_consume = 2'd0;
        exp_q.delete();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        beat(32'h0000_6000, 2'b01, 32'hFFFF_FFFF, 32'h0000_0600, 2'd0, 1'b1);
        chk("postflush_pc", 64'(out_pc[31:0]), 64'h0000_6000);
        consume(2'd1, 1);

        // Asynchronous reset with count=5.
        beat(32'h0000_7000, 2'b11, 32'h0000_0701, 32'h0000_0700, 2'd0, 1'b1);
        beat(32'h0000_7008, 2'b11, 32'h0000_0703, 32'h0000_0702, 2'd0, 1'b1);
        beat(32'h0000_7010, 2'b01, 32'hFFFF_FFFF, 32'h0000_0704, 2'd0, 1'b1);
        chk("prerst_count", 64'(count), 64'd5);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_count", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
